// File: rtl/array_multiplier.sv
// rtl/array_multiplier.sv - unsigned 4x4 FA/HA array multiplier with registered 8-bit product
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   A, B      4-bit unsigned operands
//   in_valid  A/B qualify this cycle
//   Product   registered unsigned product A*B
//   out_valid Product holds a new result this cycle
//
// Build option ARRAY_MULT_PIPE_EN: registers the array after row 2, giving latency 2.
// Otherwise the array is purely combinational into the Product register, giving latency 1.
module array_multiplier (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       in_valid,
    output logic [7:0] Product,
    output logic       out_valid
);

    // Cells return {carry, sum}.
    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

    // Carry-save rows. Row i cell j has weight i+j; s*[3] is the lone
    // top partial product of that row, which has nothing to add to it.
    logic [3:0] s1, s2, s3;
    logic [2:0] c1, c2, c3;
    logic [2:0] lo_bits;

    always_comb begin
        s1 = '0;
        c1 = '0;
        s2 = '0;
        c2 = '0;
        for (int j = 0; j < 3; j++) begin
            {c1[j], s1[j]} = ha(A[j] & B[1], A[j+1] & B[0]);
        end
        s1[3] = A[3] & B[1];
        for (int j = 0; j < 3; j++) begin
            {c2[j], s2[j]} = fa(A[j] & B[2], s1[j+1], c1[j]);
        end
        s2[3] = A[3] & B[2];
        lo_bits = {s2[0], s1[0], A[0] & B[0]};
    end

    // Boundary between row 2 and row 3.
    logic [3:0] st_a;
    logic       st_b3;
    logic [3:1] st_s2;
    logic [2:0] st_c2;
    logic [2:0] st_lo;
    logic       st_v;

`ifdef ARRAY_MULT_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            st_a  <= '0;
            st_b3 <= 1'b0;
            st_s2 <= '0;
            st_c2 <= '0;
            st_lo <= '0;
            st_v  <= 1'b0;
        end else begin
            st_a  <= A;
            st_b3 <= B[3];
            st_s2 <= s2[3:1];
            st_c2 <= c2;
            st_lo <= lo_bits;
            st_v  <= in_valid;
        end
    end
`else
    always_comb begin
        st_a  = A;
        st_b3 = B[3];
        st_s2 = s2[3:1];
        st_c2 = c2;
        st_lo = lo_bits;
        st_v  = in_valid;
    end
`endif

    // Row 3 followed by the ripple merge of its sum/carry vectors.
    logic [7:0] prod_next;
    logic       k4, k5, k6;

    always_comb begin
        s3 = '0;
        c3 = '0;
        {c3[0], s3[0]} = fa(st_a[0] & st_b3, st_s2[1], st_c2[0]);
        {c3[1], s3[1]} = fa(st_a[1] & st_b3, st_s2[2], st_c2[1]);
        {c3[2], s3[2]} = fa(st_a[2] & st_b3, st_s2[3], st_c2[2]);
        s3[3] = st_a[3] & st_b3;

        prod_next[2:0] = st_lo;
        prod_next[3]   = s3[0];
        {k4, prod_next[4]} = ha(s3[1], c3[0]);
        {k5, prod_next[5]} = fa(s3[2], c3[1], k4);
        {k6, prod_next[6]} = fa(s3[3], c3[2], k5);
        // 15*15 = 225 fits, so the top carry is the final product bit.
        prod_next[7] = k6;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Product   <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            Product   <= prod_next;
            out_valid <= st_v;
        end
    end

endmodule

// File: tb/tb_array_multiplier.sv
// tb/tb_array_multiplier.sv - directed and exhaustive bench for array_multiplier
module tb_array_multiplier;

`ifdef ARRAY_MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = 4'h0;
    logic [3:0] B = 4'h0;
    logic       in_valid = 1'b0;
    logic [7:0] Product;
    logic       out_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Reference pipeline: index LAT-1 is what the outputs should show.
    logic       mv[0:1] = '{1'b0, 1'b0};
    logic [7:0] mp[0:1] = '{8'h00, 8'h00};

    array_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .Product   (Product),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (A=%0d B=%0d t=%0t)", tag, obs, exp, A, B, $time);
        end
    endtask

    task automatic tick();
        logic [7:0] ea, eb;
        ea = {4'h0, A};
        eb = {4'h0, B};
        if (rst) begin
            mv[0] = 1'b0; mv[1] = 1'b0;
            mp[0] = 8'h00; mp[1] = 8'h00;
        end else begin
            mv[1] = mv[0];
            mp[1] = mp[0];
            mv[0] = in_valid;
            mp[0] = ea * eb;
        end
        @(posedge clk);
        #1;
        check("model_valid", {7'b0, out_valid}, {7'b0, mv[LAT-1]});
        check("model_prod", Product, mp[LAT-1]);
    endtask

    // One valid operand pair, then idle until its result is due.
    task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] exp);
        A = a;
        B = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        check({tag, "_valid"}, {7'b0, out_valid}, 8'h01);
        check(tag, Product, exp);
    endtask

    initial begin
        // Reset held with all-ones operands and valid asserted.
        rst = 1'b1;
        A = 4'hF;
        B = 4'hF;
        in_valid = 1'b1;
        tick();
        tick();
        check("rst_prod", Product, 8'h00);
        check("rst_valid", {7'b0, out_valid}, 8'h00);

        rst = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT) check("rel_valid_early", {7'b0, out_valid}, 8'h00);
        end
        check("rel_valid", {7'b0, out_valid}, 8'h01);
        check("rel_prod", Product, 8'hE1);
        in_valid = 1'b0;
        for (int k = 0; k < LAT; k++) tick();

        directed("d_15x14", 4'hF, 4'hE, 8'hD2);
        directed("d_15x15", 4'hF, 4'hF, 8'hE1);
        directed("d_0x9",   4'h0, 4'h9, 8'h00);
        directed("d_1x13",  4'h1, 4'hD, 8'h0D);
        directed("d_7x1",   4'h7, 4'h1, 8'h07);
        directed("d_8x8",   4'h8, 4'h8, 8'h40);
        directed("d_5x3",   4'h5, 4'h3, 8'h0F);
        directed("d_10x12", 4'hA, 4'hC, 8'h78);

        // All pairs back-to-back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                A = 4'(a);
                B = 4'(b);
                in_valid = 1'b1;
                tick();
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < LAT; k++) tick();

        // Valid gap pattern 1,0,1.
        A = 4'h3; B = 4'h6; in_valid = 1'b1; tick();
        A = 4'h9; B = 4'h9; in_valid = 1'b0; tick();
        A = 4'hC; B = 4'hB; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        for (int k = 0; k < LAT; k++) tick();

        // Reset with results in flight.
        A = 4'hE; B = 4'hD; in_valid = 1'b1; tick();
        A = 4'hB; B = 4'h7; in_valid = 1'b1;
        rst = 1'b1;
        tick();
        check("mid_rst_prod", Product, 8'h00);
        check("mid_rst_valid", {7'b0, out_valid}, 8'h00);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tick();
            check("post_rst_valid", {7'b0, out_valid}, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
